// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_queue_pkg;

    localparam int          XLEN         = 32;
    localparam int          INST_W       = 32;
    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
    localparam int          ENTRY_W      = XLEN + INST_W;

    // One buffered instruction: its fetch address and its encoding.
    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fq_entry_t;

    // Instruction addresses are word aligned; the low two bits are dropped.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & 32'hFFFF_FFFC;
    endfunction

    // Sequential fetch advances one word and wraps modulo 2^32.
    function automatic logic [XLEN-1:0] next_seq_pc(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush. Simultaneous push and pop are allowed even
// when full: the pop frees the slot the push fills, so count is unchanged.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head_data,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        if (p == AW'(DEPTH - 1)) begin
            return '0;
        end
        return p + AW'(1);
    endfunction

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem[rd_ptr];

    // Pointer and occupancy update; flush empties the FIFO and overrides push/pop.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CW'(1);
            end
        end
    end

    // Storage holds data only, so it is written without reset.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: owns the fetch PC, issues sequential word
// requests to instruction memory, buffers returned words with their PCs and
// hands them to decode. A redirect flushes the buffer and marks every
// in-flight request as stale so its response is dropped on arrival.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter int          MAX_OUT  = 4,
    parameter logic [31:0] RESET_PC = RESET_VECTOR
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst
);

    localparam int OW = $clog2(MAX_OUT + 1);
    localparam int QW = $clog2(DEPTH + 1);

    logic [31:0]    fetch_pc;
    logic [OW-1:0]  outstanding;
    logic [OW-1:0]  drop_cnt;
    logic [OW-1:0]  live;
    logic [15:0]    credit_sum;
    logic           req_fire;
    logic           resp_drop;
    logic           resp_live;
    logic           out_fire;

    logic [31:0]    pend_head;
    logic           pend_empty;
    logic           pend_full;
    logic [OW-1:0]  pend_count;

    fq_entry_t      q_in;
    logic [ENTRY_W-1:0] q_head_bits;
    fq_entry_t      q_head;
    logic           q_empty;
    logic           q_full;
    logic [QW-1:0]  q_count;

    // Live requests plus buffered entries may never exceed DEPTH, so every
    // live response is guaranteed a queue slot when it returns.
    assign live       = outstanding - drop_cnt;
    assign credit_sum = 16'(live) + 16'(q_count);

    assign imem_req_valid = !rst && !redirect_valid
                         && (outstanding < OW'(MAX_OUT))
                         && (credit_sum < 16'(DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response is stale while drop_cnt is non-zero; one arriving alongside a
    // redirect is also discarded because its PC belongs to the old stream.
    assign resp_drop = imem_resp_valid && (drop_cnt != '0);
    assign resp_live = imem_resp_valid && (drop_cnt == '0) && !redirect_valid;

    assign out_fire  = out_valid && out_ready;

    assign q_in.pc   = pend_head;
    assign q_in.inst = imem_resp_data;
    assign q_head    = fq_entry_t'(q_head_bits);

    assign out_valid = !q_empty;
    assign out_pc    = q_head.pc;
    assign out_inst  = q_head.inst;

    // PCs of live in-flight requests, in request order.
    fetch_fifo #(
        .WIDTH (32),
        .DEPTH (MAX_OUT)
    ) u_pend_pc (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (req_fire),
        .push_data (fetch_pc),
        .pop       (resp_live),
        .head_data (pend_head),
        .empty     (pend_empty),
        .full      (pend_full),
        .count     (pend_count)
    );

    // Returned instructions waiting for decode.
    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_data_q (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (resp_live),
        .push_data (q_in),
        .pop       (out_fire),
        .head_data (q_head_bits),
        .empty     (q_empty),
        .full      (q_full),
        .count     (q_count)
    );

    // Fetch PC: redirect target wins, otherwise advance on each accepted request.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc <= align_pc(redirect_pc);
        end else if (req_fire) begin
            fetch_pc <= next_seq_pc(fetch_pc);
        end
    end

    // In-flight accounting: total count follows handshakes and responses even
    // across a redirect; a redirect marks everything still in flight as stale.
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            case ({req_fire, imem_resp_valid})
                2'b10:   outstanding <= outstanding + OW'(1);
                2'b01:   outstanding <= outstanding - OW'(1);
                default: outstanding <= outstanding;
            endcase
            if (redirect_valid) begin
                drop_cnt <= outstanding - OW'(imem_resp_valid);
            end else if (resp_drop) begin
                drop_cnt <= drop_cnt - OW'(1);
            end
        end
    end

    // Protocol and bookkeeping invariants.
    a_no_spurious_resp: assert property (@(posedge clk) disable iff (rst)
        !(imem_resp_valid && (outstanding == '0)));
    a_pend_tracks_live: assert property (@(posedge clk) disable iff (rst)
        pend_count == live);
    a_pend_has_pc: assert property (@(posedge clk) disable iff (rst)
        !(resp_live && pend_empty));
    a_pend_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(req_fire && pend_full));
    a_queue_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(resp_live && q_full && !out_fire));

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch front end that sits directly upstream of decode. It owns the fetch PC and issues sequential word requests to instruction memory over a valid/ready request channel with in-order, variable-latency responses. It buffers returned instructions with their PCs in a small queue and hands them to decode over a valid/ready channel. On a redirect (branch, jal, jalr) it flushes the queue and discards in-flight stale responses.

## Interface
- DEPTH, 4: queue entries; power of two, at least 2.
- MAX_OUT, 4: maximum total in-flight memory requests, stale plus live.
- RESET_PC, 32'h0000_0000: fetch PC after reset.

- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  32  word address; always equals fetch_pc.
- imem_resp_valid  in  1  one response word; responses return in request order.
- imem_resp_data  in  32  instruction encoding.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  32  new fetch PC; bits [1:0] are ignored and forced to 0.
- out_valid  out  1  queue head is valid.
- out_ready  in  1  decode consumes the head.
- out_pc  out  32  PC of the head entry.
- out_inst  out  32  encoding of the head entry.

## Operation
- State:
  - fetch_pc, 32 bits.
  - outstanding, total in-flight count, 0..MAX_OUT.
  - drop_cnt, stale in-flight count, ≤ outstanding.
  - pend_pc FIFO, MAX_OUT deep: the PC of each live in-flight request.
  - Data queue: DEPTH entries of {pc, inst}, with count 0..DEPTH.
- live = outstanding − drop_cnt.
- imem_req_valid = !redirect_valid && outstanding < MAX_OUT && (live + count) < DEPTH.
  - This credit rule guarantees a live response always finds space in the queue.
- Request handshake (valid && ready):
  - push fetch_pc to pend_pc;
  - fetch_pc += 4, wrapping modulo 2^32;
  - outstanding += 1.
- Response (imem_resp_valid):
  - outstanding −= 1.
  - If drop_cnt > 0: drop_cnt −= 1 and discard the data.
  - Otherwise: pop pend_pc and enqueue {pend_pc head, imem_resp_data}.
- Pop on out_valid && out_ready.
- The queue must support enqueue and pop in the same cycle, including when count == DEPTH; count is then unchanged.
- Redirect (takes priority over everything except rst):
  - fetch_pc ← {redirect_pc[31:2], 2'b00}.
  - Data queue and pend_pc are cleared; count ← 0.
  - drop_cnt ← outstanding − imem_resp_valid.
  - A response arriving in the redirect cycle is discarded.
  - outstanding updates normally for that response.
  - No request is issued in the redirect cycle.
  - A pop accepted in the redirect cycle is a completed transfer.
- The memory must not assert a response with zero outstanding requests. Behaviour in that case is undefined; an assertion flags it.

## Timing
- Reset values:
  - fetch_pc = RESET_PC;
  - outstanding = drop_cnt = count = 0;
  - out_valid = 0;
  - imem_req_valid = 0 while rst is high.
- imem_req_valid may first rise in the cycle after rst deasserts.
- Asserting rst mid-operation discards all in-flight state. Responses to requests issued before reset are the memory's responsibility; the memory is reset on the same rst.
- Latency: a response accepted in cycle N appears at out_* in cycle N+1. There is no combinational bypass from imem_resp to out_*.
- out_pc and out_inst come straight from registers. They are stable while out_valid && !out_ready.
- With a 1-cycle memory and decode always ready, the block sustains one instruction per cycle.
- The first instruction after a redirect in cycle R is requested in R+1 and reaches out_valid at R+3 or later.
- imem_req_valid may drop without a handshake when a redirect arrives. The memory samples only valid && ready.

## Structure
- Shared header decode.vh gains `RESET_VECTOR (the RESET_PC default) and `INST_W = 32.
- cpu consumes out_*.
  - decode sources next_pc_sel.
  - The pc-adder logic generates redirect_valid/redirect_pc for any pc_sel other than `PC_FROM_PC_PLUS_4.
- One sub-module, fetch_fifo:
  - synchronous FIFO with parameters WIDTH and DEPTH, plus a flush input;
  - instantiated twice: data queue (WIDTH 64) and pend_pc (WIDTH 32, DEPTH MAX_OUT).

## Test plan
- Reset release, 1-cycle memory, out_ready = 1:
  - out_pc sequence is 0x0, 0x4, 0x8, … on consecutive cycles starting 2 cycles after reset;
  - out_inst matches memory.
- out_ready held at 0, then 1:
  - exactly 4 requests issue, then imem_req_valid = 0 with count = 4;
  - the head holds PC 0x0 stably;
  - releasing out_ready drains 0x0..0xC in order, and fetch resumes at 0x10.
- 3-cycle memory latency with 3 requests in flight, then redirect to 0x103:
  - fetch restarts at 0x100;
  - the next 3 responses are dropped;
  - the first out_pc after the redirect is 0x100.
- Redirect in the same cycle as a response and as an out handshake:
  - the response is discarded and drop_cnt = outstanding − 1;
  - the popped entry counts as delivered;
  - the next delivered PC is the redirect target.
- Back-to-back redirects to 0x40, then 0x80, one cycle apart under a 4-cycle latency:
  - outstanding never exceeds MAX_OUT;
  - only 0x80, 0x84, … are delivered.
- Fetch wrap-around with RESET_PC = 0xFFFF_FFF8:
  - delivered PCs are 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
